elevator_sched: RTL and testbench
=================================

# elevator_sched

Per-car motion sequencer for the two-car elevator system. Owns the current-floor and direction registers of both cars and steps each car through decide / travel / door / turn phases. Consumes the per-car `turn` and `hold` flags from the direction-decision logic and feeds `curr_elevator_*` and `dir_elevator` back to it and to the boarding logic. Floors are numbered 1..7; direction bit 1 = up, 0 = down.

## Interface
- `MOVE_CYCLES`, default 8: clock cycles to travel one floor (≥2).
- `DOOR_CYCLES`, default 4: clock cycles the door stays open per stop (≥1).
- `clk`  in  1  system clock, rising edge.
- `rst_n`  in  1  reset; synchronous, active-low.
- `run`  in  1  global enable; when low, all counters and states freeze, outputs hold.
- `turn`  in  2  `{turn_1, turn_2}`: car has no work ahead in its current direction.
- `hold_1`, `hold_2`  in  1  passengers waiting at the car's current floor in its direction.
- `curr_elevator_1`, `curr_elevator_2`  out  3  current floor, 1..7.
- `dir_elevator`  out  2  `{dir_1, dir_2}`.
- `door_1`, `door_2`  out  1  door open (high for the whole DOOR phase).
- `board_1`, `board_2`  out  1  one-cycle strobe on entry to DOOR; boarding logic loads/unloads on it.
- `parked_1`, `parked_2`  out  1  car idle, no work in either direction.

## Operation
- Reset values: `curr_elevator_1`=1, `curr_elevator_2`=7, `dir_elevator`=2'b10, doors 0, board 0, parked 0, both FSMs in DECIDE, counters 0.
- Each car runs an identical independent FSM; car 1 uses `turn[1]`/`hold_1`, car 2 uses `turn[0]`/`hold_2`.
- DECIDE (1 cycle), checked in priority order:
  - `hold` → DOOR, load dwell counter `DOOR_CYCLES-1`, assert board for this transition's first DOOR cycle; clear parked.
  - `turn` and previous phase was TURN → stay in DECIDE, set parked (no direction flip; prevents endless reversal).
  - `turn`, or at floor 7 with dir up, or at floor 1 with dir down → TURN.
  - else → TRAVEL, load counter `MOVE_CYCLES-1`; clear parked.
- TRAVEL: decrement each cycle; at 0, floor ±1 per dir, → DECIDE. Floor never leaves 1..7 (end floors are caught in DECIDE).
- DOOR: `door`=1; decrement; at 0 → DECIDE with door=0 next cycle. `hold` is ignored during DOOR; still-waiting passengers reopen the door via the next DECIDE.
- TURN (1 cycle): invert dir bit → DECIDE. Parked car leaves park as soon as DECIDE sees `hold` or a cleared `turn`.
- `run` low: no state, counter or output change; `board` is forced 0 while frozen and is not re-emitted on resume.
- Reset asserted mid-TRAVEL/DOOR: next edge restores reset values regardless of phase.

## Timing
- All outputs are registered; input flags are sampled only in DECIDE.
- Floor-to-floor stop-free travel: `MOVE_CYCLES+1` cycles per floor (TRAVEL + DECIDE).
- Stop: `DOOR_CYCLES` cycles door high, then 1 DECIDE cycle.
- Reversal: 2 cycles (TURN + DECIDE) before the car can move.
- `board_x` coincides with the first cycle `door_x`=1; `curr_elevator_x` is stable during DOOR.
- Inputs from the decision block are combinational functions of these outputs; they settle within the DECIDE cycle's preceding period, so no extra pipeline stage is required.

## Structure
- Package `elevator_pkg`: `FLOOR_MIN`=1, `FLOOR_MAX`=7, `DIR_UP`=1, `DIR_DOWN`=0, car state enum {DECIDE, TRAVEL, DOOR, TURN}.
- One sub-module `car_fsm` (params MOVE_CYCLES, DOOR_CYCLES, reset floor, reset dir), instantiated twice; top level only maps `turn` bits and concatenates `dir_elevator`.

## Test plan
- Reset: drive `rst_n`=0 for 2 cycles → floors 1/7, dir 2'b10, doors/board/parked 0.
- Free travel: turn=0, hold=0, MOVE_CYCLES=8 → car 1 reaches floor 2 exactly 9 cycles after reset release, floor 7 after 54; then reverses (dir_1=0) within 2 cycles without `turn`.
- Stop: hold_1=1 at floor 3 → board_1 single-cycle pulse, door_1 high exactly 4 cycles, floor stays 3; hold_1 still 1 → door reopens after 1 DECIDE cycle.
- Turn/park: car 2 at floor 7 down, turn[0]=1 held → one flip to up, then parked_2=1, dir unchanged; drop turn[0] → parked_2=0, car moves.
- Freeze: `run`=0 mid-TRAVEL for 10 cycles → floor and remaining count unchanged; arrival delayed by exactly 10 cycles.
- Reset mid-DOOR: rst_n=0 during door_1=1 → next cycle door_1=0, floor 1, state DECIDE.

Source files
------------

// File: rtl/elevator_pkg.sv
// Shared constants and types for the two-car elevator sequencer.
//   FLOOR_MIN / FLOOR_MAX : floor number range (1..7)
//   DIR_UP / DIR_DOWN     : encoding of a car's direction bit
//   car_state_e           : per-car phase
package elevator_pkg;

   localparam logic [2:0] FLOOR_MIN = 3'd1;
   localparam logic [2:0] FLOOR_MAX = 3'd7;
   localparam logic       DIR_UP    = 1'b1;
   localparam logic       DIR_DOWN  = 1'b0;

   typedef enum logic [1:0] {
      DECIDE,
      TRAVEL,
      DOOR,
      TURN
   } car_state_e;

endpackage

// File: rtl/elevator_sched_car_fsm.sv
// Motion sequencer for a single elevator car: decide / travel / door / turn.
// Ports:
//   i_clk, i_rst_n (sync, active-low), i_run (global freeze when low)
//   i_turn   : no work ahead in the current direction
//   i_hold   : passengers waiting at the current floor in the current direction
//   o_floor  : current floor 1..7          o_dir    : 1 = up, 0 = down
//   o_door   : door open (whole DOOR phase) o_board  : strobe on DOOR entry
//   o_parked : car idle with no work in either direction
module car_fsm
   import elevator_pkg::*;
#(
   parameter int unsigned MOVE_CYCLES = 8,
   parameter int unsigned DOOR_CYCLES = 4,
   parameter logic [2:0]  RESET_FLOOR = 3'd1,
   parameter logic        RESET_DIR   = 1'b1
) (
   input  logic       i_clk,
   input  logic       i_rst_n,
   input  logic       i_run,
   input  logic       i_turn,
   input  logic       i_hold,
   output logic [2:0] o_floor,
   output logic       o_dir,
   output logic       o_door,
   output logic       o_board,
   output logic       o_parked
);

   localparam int unsigned CNT_MAX = (MOVE_CYCLES > DOOR_CYCLES) ? MOVE_CYCLES : DOOR_CYCLES;
   localparam int unsigned CNT_W   = $clog2(CNT_MAX);
   localparam logic [CNT_W-1:0] MOVE_LOAD = CNT_W'(MOVE_CYCLES - 1);
   localparam logic [CNT_W-1:0] DOOR_LOAD = CNT_W'(DOOR_CYCLES - 1);

   car_state_e       r_state, w_state;
   logic [CNT_W-1:0] r_cnt, w_cnt;
   logic [2:0]       r_floor, w_floor;
   logic             r_dir, w_dir;
   logic             r_door, w_door;
   logic             r_board, w_board;
   logic             r_parked, w_parked;
   // Set when DECIDE was reached from TURN (or is parked); blocks a second reversal.
   logic             r_from_turn, w_from_turn;

   always_comb begin
      w_state     = r_state;
      w_cnt       = r_cnt;
      w_floor     = r_floor;
      w_dir       = r_dir;
      w_door      = r_door;
      w_board     = 1'b0;  // strobe; also forced low while frozen
      w_parked    = r_parked;
      w_from_turn = r_from_turn;
      if (i_run) begin
         unique case (r_state)
            DECIDE: begin
               if (i_hold) begin
                  w_state     = DOOR;
                  w_cnt       = DOOR_LOAD;
                  w_door      = 1'b1;
                  w_board     = 1'b1;
                  w_parked    = 1'b0;
                  w_from_turn = 1'b0;
               end else if (i_turn && r_from_turn) begin
                  w_parked = 1'b1;
               end else if (i_turn ||
                            (r_floor == FLOOR_MAX && r_dir == DIR_UP) ||
                            (r_floor == FLOOR_MIN && r_dir == DIR_DOWN)) begin
                  w_state  = TURN;
                  w_parked = 1'b0;
               end else begin
                  w_state     = TRAVEL;
                  w_cnt       = MOVE_LOAD;
                  w_parked    = 1'b0;
                  w_from_turn = 1'b0;
               end
            end
            TRAVEL: begin
               if (r_cnt == '0) begin
                  w_state = DECIDE;
                  w_floor = (r_dir == DIR_UP) ? r_floor + 3'd1 : r_floor - 3'd1;
               end else begin
                  w_cnt = r_cnt - 1'b1;
               end
            end
            DOOR: begin
               if (r_cnt == '0) begin
                  w_state = DECIDE;
                  w_door  = 1'b0;
               end else begin
                  w_cnt = r_cnt - 1'b1;
               end
            end
            TURN: begin
               w_dir       = ~r_dir;
               w_state     = DECIDE;
               w_from_turn = 1'b1;
            end
            default: w_state = DECIDE;
         endcase
      end
   end

   always_ff @(posedge i_clk) begin
      if (!i_rst_n) begin
         r_state     <= DECIDE;
         r_cnt       <= '0;
         r_floor     <= RESET_FLOOR;
         r_dir       <= RESET_DIR;
         r_door      <= 1'b0;
         r_board     <= 1'b0;
         r_parked    <= 1'b0;
         r_from_turn <= 1'b0;
      end else begin
         r_state     <= w_state;
         r_cnt       <= w_cnt;
         r_floor     <= w_floor;
         r_dir       <= w_dir;
         r_door      <= w_door;
         r_board     <= w_board;
         r_parked    <= w_parked;
         r_from_turn <= w_from_turn;
      end
   end

   assign o_floor  = r_floor;
   assign o_dir    = r_dir;
   assign o_door   = r_door;
   assign o_board  = r_board;
   assign o_parked = r_parked;

endmodule

// File: rtl/elevator_sched.sv
// Two-car elevator motion sequencer: one car_fsm per car.
// Ports:
//   i_clk, i_rst_n (sync, active-low), i_run (global freeze when low)
//   i_turn = {turn_1, turn_2}, i_hold_1, i_hold_2 : flags from the decision logic
//   o_curr_elevator_1/2 : current floors      o_dir_elevator = {dir_1, dir_2}
//   o_door_1/2, o_board_1/2, o_parked_1/2   : per-car status
module elevator_sched
   import elevator_pkg::*;
#(
   parameter int unsigned MOVE_CYCLES = 8,
   parameter int unsigned DOOR_CYCLES = 4
) (
   input  logic       i_clk,
   input  logic       i_rst_n,
   input  logic       i_run,
   input  logic [1:0] i_turn,
   input  logic       i_hold_1,
   input  logic       i_hold_2,
   output logic [2:0] o_curr_elevator_1,
   output logic [2:0] o_curr_elevator_2,
   output logic [1:0] o_dir_elevator,
   output logic       o_door_1,
   output logic       o_door_2,
   output logic       o_board_1,
   output logic       o_board_2,
   output logic       o_parked_1,
   output logic       o_parked_2
);

   logic w_dir_1;
   logic w_dir_2;

   car_fsm #(
      .MOVE_CYCLES (MOVE_CYCLES),
      .DOOR_CYCLES (DOOR_CYCLES),
      .RESET_FLOOR (FLOOR_MIN),
      .RESET_DIR   (DIR_UP)
   ) u_car_1 (
      .i_clk    (i_clk),
      .i_rst_n  (i_rst_n),
      .i_run    (i_run),
      .i_turn   (i_turn[1]),
      .i_hold   (i_hold_1),
      .o_floor  (o_curr_elevator_1),
      .o_dir    (w_dir_1),
      .o_door   (o_door_1),
      .o_board  (o_board_1),
      .o_parked (o_parked_1)
   );

   car_fsm #(
      .MOVE_CYCLES (MOVE_CYCLES),
      .DOOR_CYCLES (DOOR_CYCLES),
      .RESET_FLOOR (FLOOR_MAX),
      .RESET_DIR   (DIR_DOWN)
   ) u_car_2 (
      .i_clk    (i_clk),
      .i_rst_n  (i_rst_n),
      .i_run    (i_run),
      .i_turn   (i_turn[0]),
      .i_hold   (i_hold_2),
      .o_floor  (o_curr_elevator_2),
      .o_dir    (w_dir_2),
      .o_door   (o_door_2),
      .o_board  (o_board_2),
      .o_parked (o_parked_2)
   );

   assign o_dir_elevator = {w_dir_1, w_dir_2};

endmodule

// File: tb/tb_elevator_sched.sv
// Directed bench for elevator_sched (MOVE_CYCLES=8, DOOR_CYCLES=4).
// Cycle numbers below count rising edges after reset release.
module tb_elevator_sched;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       run;
   logic [1:0] turn;
   logic       hold_1;
   logic       hold_2;
   logic [2:0] floor_1;
   logic [2:0] floor_2;
   logic [1:0] dir;
   logic       door_1, door_2;
   logic       board_1, board_2;
   logic       parked_1, parked_2;

   int total = 0;
   int bad   = 0;
   int cyc   = 0;

   elevator_sched #(
      .MOVE_CYCLES (8),
      .DOOR_CYCLES (4)
   ) dut (
      .i_clk             (clk),
      .i_rst_n           (rst_n),
      .i_run             (run),
      .i_turn            (turn),
      .i_hold_1          (hold_1),
      .i_hold_2          (hold_2),
      .o_curr_elevator_1 (floor_1),
      .o_curr_elevator_2 (floor_2),
      .o_dir_elevator    (dir),
      .o_door_1          (door_1),
      .o_door_2          (door_2),
      .o_board_1         (board_1),
      .o_board_2         (board_2),
      .o_parked_1        (parked_1),
      .o_parked_2        (parked_2)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input int obs, input int exp);
      total++;
      assert (obs === exp)
      else begin
         bad++;
         $error("FAIL %s at cycle %0d: observed %0d expected %0d", tag, cyc, obs, exp);
      end
   endtask

   // Advance to 1 time unit after edge number e.
   task automatic go_to(input int e);
      while (cyc < e) begin
         @(posedge clk);
         #1;
         cyc++;
      end
   endtask

   initial begin
      rst_n  = 1'b0;
      run    = 1'b1;
      turn   = 2'b01;  // car 2 has no work: it should flip once then park
      hold_1 = 1'b0;
      hold_2 = 1'b0;
      repeat (2) begin
         @(posedge clk);
         #1;
      end
      chk("rst_floor_1", int'(floor_1), 1);
      chk("rst_floor_2", int'(floor_2), 7);
      chk("rst_dir", int'(dir), 2);
      chk("rst_door", int'({door_1, door_2}), 0);
      chk("rst_board", int'({board_1, board_2}), 0);
      chk("rst_parked", int'({parked_1, parked_2}), 0);

      rst_n = 1'b1;
      cyc   = 0;

      // Car 2: TURN at 1, flip up at 2, parked at 3
      go_to(1);
      chk("c2_turn_phase_dir", int'(dir), 2);
      go_to(2);
      chk("c2_flip_dir", int'(dir), 3);
      chk("c2_not_yet_parked", int'(parked_2), 0);
      go_to(3);
      chk("c2_parked", int'(parked_2), 1);
      chk("c2_park_floor", int'(floor_2), 7);
      go_to(5);
      chk("c2_still_parked", int'(parked_2), 1);
      chk("c2_no_second_flip", int'(dir), 3);
      turn = 2'b00;
      // At floor 7 going up: clearing turn leaves park via an end-floor reversal
      go_to(6);
      chk("c2_unpark", int'(parked_2), 0);
      go_to(7);
      chk("c2_dir_down", int'(dir), 2);

      // Car 1 free travel: floor 2 exactly at edge 9
      go_to(8);
      chk("c1_floor_before", int'(floor_1), 1);
      go_to(9);
      chk("c1_floor2_at9", int'(floor_1), 2);

      go_to(15);
      chk("c2_still_7", int'(floor_2), 7);
      go_to(16);
      chk("c2_moved_to_6", int'(floor_2), 6);
      turn = 2'b01;  // park car 2 again at floor 6 (flip up at 18, park at 19)
      go_to(18);
      chk("c1_floor3_at18", int'(floor_1), 3);
      go_to(19);
      chk("c2_reparked", int'(parked_2), 1);
      chk("c2_repark_dir", int'(dir), 3);

      go_to(53);
      chk("c1_floor6_at53", int'(floor_1), 6);
      go_to(54);
      chk("c1_floor7_at54", int'(floor_1), 7);
      go_to(55);
      chk("c1_turn_phase", int'(dir), 3);
      go_to(56);
      chk("c1_auto_reverse", int'(dir), 1);
      chk("c1_top_floor", int'(floor_1), 7);

      // Freeze mid-TRAVEL (count 4 remaining) for edges 61..70
      go_to(60);
      run = 1'b0;
      go_to(65);
      chk("frz_floor", int'(floor_1), 7);
      chk("frz_parked_2", int'(parked_2), 1);
      go_to(70);
      chk("frz_floor_end", int'(floor_1), 7);
      run = 1'b1;
      go_to(74);
      chk("frz_not_arrived", int'(floor_1), 7);
      go_to(75);
      chk("frz_arrival_delayed", int'(floor_1), 6);

      go_to(84);
      chk("c1_floor5", int'(floor_1), 5);
      go_to(102);
      chk("c1_floor3_down", int'(floor_1), 3);
      hold_1 = 1'b1;

      // Stop at floor 3: door 103..106, DECIDE at 107, reopen at 108
      go_to(103);
      chk("stop_door_open", int'(door_1), 1);
      chk("stop_board", int'(board_1), 1);
      chk("stop_floor", int'(floor_1), 3);
      go_to(104);
      chk("stop_board_single", int'(board_1), 0);
      chk("stop_door_held", int'(door_1), 1);
      go_to(106);
      chk("stop_door_last", int'(door_1), 1);
      chk("stop_floor_stable", int'(floor_1), 3);
      go_to(107);
      chk("stop_door_closed", int'(door_1), 0);
      chk("stop_no_board", int'(board_1), 0);
      chk("stop_dir", int'(dir), 1);
      go_to(108);
      chk("reopen_door", int'(door_1), 1);
      chk("reopen_board", int'(board_1), 1);

      // Reset mid-DOOR
      rst_n = 1'b0;
      go_to(109);
      chk("rst_door_mid", int'(door_1), 0);
      chk("rst_board_mid", int'(board_1), 0);
      chk("rst_floor1_mid", int'(floor_1), 1);
      chk("rst_floor2_mid", int'(floor_2), 7);
      chk("rst_dir_mid", int'(dir), 2);
      chk("rst_parked_mid", int'({parked_1, parked_2}), 0);

      // Back in DECIDE after release: with hold_1 still high the door opens at once
      rst_n = 1'b1;
      go_to(110);
      chk("post_rst_decide_door", int'(door_1), 1);
      chk("post_rst_floor", int'(floor_1), 1);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
